team_06_dac_i2s_tx: RTL and testbench
=====================================

TEAM_06_DAC_I2S_TX -- requirements
Module: team_06_dac_i2s_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per bclk half-period; legal range 2..255.
REQ-002 SHALL have parameter DATA_W, default 16: sample width; legal range 8..32.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port sample_in, input, DATA_W: signed two's-complement sample.
REQ-006 SHALL have port sample_valid, input, 1: sample_in is valid.
REQ-007 SHALL have port sample_ready, output, 1: the holding register can accept a sample.
REQ-008 SHALL have port bclk, output, 1: I2S bit clock.
REQ-009 SHALL have port ws, output, 1: word select; 0 = left, 1 = right.
REQ-010 SHALL have port sd, output, 1: serial data, MSB first.
REQ-011 SHALL have port frame_start, output, 1: one-cycle pulse when a frame's first bit is driven.
REQ-012 SHALL have port underrun, output, 1: one-cycle pulse when a frame starts with no held sample.
REQ-013 SHALL have port underrun_count, output, 8: saturating underrun counter (see Configuration).

Function
REQ-014 SHALL toggle bclk every CLK_DIV clk cycles using a divider counter; bclk is a registered output.
REQ-015 SHALL update ws, sd and the bit index (0..63) only in the clk cycle in which bclk goes 1->0 (fall event); the index increments by one per fall event and wraps from 63 to 0.
REQ-016 SHALL drive ws=1 for bit indices 31..62 and ws=0 otherwise, so ws changes one bclk before each slot MSB.
REQ-017 SHALL drive, for each slot (left: indices 0..31, right: indices 32..63), the DATA_W sample bits MSB first starting at the slot's first index, followed by zeros.
REQ-018 SHALL be mono: the same frame sample is transmitted in both the left and right slots.
REQ-019 SHALL hold one sample in a one-deep holding register; sample_ready = !hold_full; a transfer occurs when sample_valid && sample_ready.
REQ-020 At the fall event wrapping 63->0 with hold_full=1, SHALL move the held sample into the frame register, clear hold_full and pulse frame_start in the same cycle.
REQ-021 At the wrap with hold_full=0, SHALL transmit all-zero slots for that frame and pulse underrun and frame_start in that cycle.
REQ-022 A transfer in the same cycle as the wrap while hold_full=0 SHALL fill the holding register for the next frame only; the current frame still underruns (no bypass).
REQ-023 SHALL keep sample_in stable-independent: the held sample is latched at transfer and later changes to sample_in have no effect.

Reset
REQ-024 On rst=1 at a clk edge, SHALL set bclk=0, ws=0, sd=0, divider=0, bit index=63, hold_full=0, frame register=0, frame_start=0, underrun=0, underrun_count=0; sample_ready=1 in the next cycle.
REQ-025 Reset asserted mid-frame SHALL discard the held and in-flight samples; the first fall event after reset release wraps the index to 0 and starts a new frame.

Configuration
REQ-026 With macro TEAM_06_DAC_I2S_TX_UNDERRUN_CNT_EN defined, SHALL increment underrun_count on each underrun pulse, saturating at 255 and cleared only by rst.
REQ-027 Without TEAM_06_DAC_I2S_TX_UNDERRUN_CNT_EN, SHALL tie underrun_count to 0 and synthesize no counter; the underrun pulse is unaffected.

Verification (CLK_DIV=2, DATA_W=16)
REQ-028 Release reset, hold sample_valid=0 -> bclk period is 4 clk; first fall at cycle 4 after release; frame_start and underrun pulse there; sd=0 for the whole frame.
REQ-029 Load 16'hA5C3 before the first wrap -> sd carries A5C3 MSB first at indices 0..15 and 32..47 and zeros elsewhere; ws=1 exactly at indices 31..62.
REQ-030 sample_valid held high with values 1,2,3 -> sample_ready drops after each acceptance and reasserts in the wrap cycle; consecutive frames carry 1, 2, 3 with no underrun.
REQ-031 Transfer in the exact wrap cycle with hold empty -> that frame underruns with zeros; the next frame carries the sample.
REQ-032 300 consecutive underrun frames with macro defined -> underrun_count=255; without macro -> underrun_count=0.
REQ-033 rst pulsed at bit index 20 of a loaded frame -> all outputs at reset values next cycle; the held sample is lost; the frame after release underruns.

Source files
------------

// File: rtl/team_06_dac_i2s_tx.sv
// team_06_dac_i2s_tx: mono I2S transmitter fed through a one-deep sample holding register.
// Optional saturating underrun counter, enabled by defining TEAM_06_DAC_I2S_TX_UNDERRUN_CNT_EN.
module team_06_dac_i2s_tx #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              bclk,
  output logic              ws,
  output logic              sd,
  output logic              frame_start,
  output logic              underrun,
  output logic [7:0]        underrun_count
);

  localparam int               DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]  r_div;
  logic              r_bclk;
  logic              r_ws;
  logic              r_sd;
  logic [5:0]        r_idx;
  logic [DATA_W-1:0] r_hold;
  logic              r_hold_full;
  logic [DATA_W-1:0] r_frame;
  logic [DATA_W-1:0] r_shift;
  logic              r_frame_start;
  logic              r_underrun;

  logic              w_div_tc;
  logic              w_fall;
  logic              w_wrap;
  logic              w_xfer;
  logic [5:0]        w_idx_next;
  logic [DATA_W-1:0] w_frame_next;
  logic              w_ws_next;
  logic              w_sd_next;
  logic [DATA_W-1:0] w_shift_next;

  always_comb begin
    w_div_tc     = (r_div == DIV_TC);
    w_fall       = w_div_tc && r_bclk;
    w_wrap       = w_fall && (r_idx == 6'd63);
    w_xfer       = sample_valid && !r_hold_full;
    w_idx_next   = r_idx + 6'd1;
    w_frame_next = r_frame;
    if (w_wrap) begin
      w_frame_next = r_hold_full ? r_hold : '0;
    end
    // ws leads each slot MSB by one bit clock
    w_ws_next = (w_idx_next >= 6'd31) && (w_idx_next <= 6'd62);
    // each slot reloads the shifter; zeros shift in once the sample is exhausted
    if (w_idx_next[4:0] == 5'd0) begin
      {w_sd_next, w_shift_next} = {w_frame_next, 1'b0};
    end else begin
      {w_sd_next, w_shift_next} = {r_shift, 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
    end else if (w_div_tc) begin
      r_div  <= '0;
      r_bclk <= ~r_bclk;
    end else begin
      r_div  <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx         <= 6'd63;
      r_ws          <= 1'b0;
      r_sd          <= 1'b0;
      r_frame       <= '0;
      r_shift       <= '0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_frame_start <= w_wrap;
      r_underrun    <= w_wrap && !r_hold_full;
      if (w_fall) begin
        r_idx   <= w_idx_next;
        r_ws    <= w_ws_next;
        r_sd    <= w_sd_next;
        r_shift <= w_shift_next;
        r_frame <= w_frame_next;
      end
    end
  end

  // a transfer coinciding with an empty-hold wrap only refills for the next frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_xfer) begin
      r_hold      <= sample_in;
      r_hold_full <= 1'b1;
    end else if (w_wrap) begin
      r_hold_full <= 1'b0;
    end
  end

`ifdef TEAM_06_DAC_I2S_TX_UNDERRUN_CNT_EN
  logic [7:0] r_underrun_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_underrun_cnt <= 8'd0;
    end else if (w_wrap && !r_hold_full && (r_underrun_cnt != 8'hFF)) begin
      r_underrun_cnt <= r_underrun_cnt + 8'd1;
    end
  end

  assign underrun_count = r_underrun_cnt;
`else
  assign underrun_count = 8'd0;
`endif

  assign sample_ready = !r_hold_full;
  assign bclk         = r_bclk;
  assign ws           = r_ws;
  assign sd           = r_sd;
  assign frame_start  = r_frame_start;
  assign underrun     = r_underrun;

endmodule

// File: tb/tb_team_06_dac_i2s_tx.sv
// Scoreboard bench for team_06_dac_i2s_tx (CLK_DIV=2, DATA_W=16): stimulus queues expected
// frames, a monitor captures each transmitted frame off bclk falls and compares it.
`timescale 1ns/1ps
module tb_team_06_dac_i2s_tx;
  localparam int CLK_DIV = 2;
  localparam int DATA_W  = 16;
`ifdef TEAM_06_DAC_I2S_TX_UNDERRUN_CNT_EN
  localparam bit UCNT_EN = 1'b1;
`else
  localparam bit UCNT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] sample_in = '0;
  logic              sample_valid = 1'b0;
  logic              sample_ready;
  logic              bclk;
  logic              ws;
  logic              sd;
  logic              frame_start;
  logic              underrun;
  logic [7:0]        underrun_count;

  always #5 clk = ~clk;

  team_06_dac_i2s_tx #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .bclk(bclk), .ws(ws), .sd(sd),
    .frame_start(frame_start), .underrun(underrun), .underrun_count(underrun_count)
  );

  typedef struct packed {
    logic        urun;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic u, input logic [15:0] d);
    exp_t e;
    e.urun = u;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  logic        prev_bclk = 1'b0;
  logic        in_frame  = 1'b0;
  logic        m_fall;
  int          nbits     = 0;
  int          stray     = 0;
  int          mdl_ucnt  = 0;
  logic [63:0] cap_sd;
  logic [63:0] cap_ws;
  logic [15:0] w_left;
  logic [15:0] w_right;
  exp_t        cur;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame  = 1'b0;
        prev_bclk = 1'b0;
        mdl_ucnt  = 0;
        stray     = 0;
      end else begin
        m_fall = prev_bclk && !bclk;
        if ((frame_start && !m_fall) || (underrun && !frame_start)) stray++;
        if (m_fall && frame_start) begin
          if (in_frame) check("frame_len", nbits, 64);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_frame: frame_start with no expected frame at t=%0t", $time);
            in_frame = 1'b0;
          end else begin
            cur = exp_q.pop_front();
            in_frame = 1'b1;
            nbits    = 0;
            check("underrun_flag", underrun, cur.urun);
            if (cur.urun) mdl_ucnt = (mdl_ucnt < 255) ? mdl_ucnt + 1 : 255;
            check("underrun_count", underrun_count, UCNT_EN ? mdl_ucnt : 0);
          end
        end
        if (m_fall && in_frame) begin
          cap_sd[nbits] = sd;
          cap_ws[nbits] = ws;
          nbits++;
          if (nbits == 64) begin
            for (int k = 0; k < 16; k++) begin
              w_left[15-k]  = cap_sd[k];
              w_right[15-k] = cap_sd[32+k];
            end
            check("sd_left", w_left, cur.data);
            check("sd_left_pad", cap_sd[31:16], 0);
            check("sd_right", w_right, cur.data);
            check("sd_right_pad", cap_sd[63:48], 0);
            check("ws_left_slot", cap_ws[31:0], 32'h8000_0000);
            check("ws_right_slot", cap_ws[63:32], 32'h7FFF_FFFF);
            check("stray_pulses", stray, 0);
            stray    = 0;
            in_frame = 1'b0;
          end
        end
        prev_bclk = bclk;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [15:0] d, input bit keep);
    bit seen_low = 1'b0;
    bit ok       = 1'b0;
    sample_in    = d;
    sample_valid = 1'b1;
    if (keep) push_exp(1'b0, d);
    for (int k = 0; k < 2000 && !ok; k++) begin
      if (sample_ready) begin
        if (seen_low) check("ready_at_wrap", frame_start, 1);
        @(negedge clk);
        check("ready_drop", sample_ready, 0);
        ok = 1'b1;
      end else begin
        seen_low = 1'b1;
        @(negedge clk);
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: sample %h never accepted", d);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc != n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_cyc: cycle %0d actual, %0d required", cyc, n);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_bclk"}, bclk, 0);
    check({tag, "_ws"}, ws, 0);
    check({tag, "_sd"}, sd, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_underrun"}, underrun, 0);
    check({tag, "_underrun_count"}, underrun_count, 0);
    check({tag, "_ready"}, sample_ready, 1);
  endtask

  logic [7:0] bwave;
  bit         fin;

  initial begin
    bwave = 8'b0110_0110;
    repeat (3) @(negedge clk);
    check_reset("rst0");

    // frame 0 underruns; bclk period 4, first fall at cycle 4
    push_exp(1'b1, 16'h0000);
    rst = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("bclk_wave", bclk, bwave[c-1]);
      check("first_frame_start", frame_start, (c == 4));
    end

    // A5C3 loaded during frame 0 -> frame 1; input changes afterwards are ignored
    send(16'hA5C3, 1'b1);
    sample_valid = 1'b0;
    sample_in    = 16'hFFFF;
    repeat (20) @(negedge clk);

    // back-to-back samples 1,2,3 -> frames 2,3,4
    send(16'h0001, 1'b1);
    send(16'h0002, 1'b1);
    send(16'h0003, 1'b1);
    sample_valid = 1'b0;
    sample_in    = '0;

    // transfer exactly at the frame-5 wrap with hold empty
    wait_cyc(1283);
    push_exp(1'b1, 16'h0000);
    push_exp(1'b0, 16'h8001);
    sample_in    = 16'h8001;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check("wrap_xfer_ready", sample_ready, 0);
    check("wrap_xfer_underrun", underrun, 1);

    // reset at bit index 20 of frame 6 with another sample held (lost)
    wait_cyc(1560);
    send(16'h7FFE, 1'b0);
    sample_valid = 1'b0;
    wait_cyc(1620);
    rst = 1'b1;
    @(negedge clk);
    check_reset("mid_rst");
    repeat (2) @(negedge clk);

    // every frame after release underruns; counter saturates
    for (int f = 0; f < 257; f++) push_exp(1'b1, 16'h0000);
    rst = 1'b0;

    fin = 1'b0;
    for (int k = 0; k < 70000 && !fin; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !in_frame) fin = 1'b1;
    end
    if (!fin) begin
      n_vec++;
      n_err++;
      $display("FAIL completion_timeout: %0d frames still pending", exp_q.size());
    end
    check("final_underrun_count", underrun_count, UCNT_EN ? 255 : 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
